// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared decode constants, producer classes and helpers for hazard_ctrl
// Purpose : opcode/funct constants, producer-class enum, T_new/T_use encodings,
//           forwarding-select encodings and the combinational classifiers.
// Ports   : none (package).
package hazard_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2a;
  localparam logic [5:0] FN_SLTU  = 6'h2b;

  typedef enum logic [1:0] {CLS_NONE, CLS_ALU, CLS_LOAD, CLS_LINK} prod_cls_t;

  // T_INF marks an operand that is never read, so it can never cause a stall.
  typedef logic [1:0] tval_t;
  localparam tval_t T_0   = 2'd0;
  localparam tval_t T_1   = 2'd1;
  localparam tval_t T_2   = 2'd2;
  localparam tval_t T_INF = 2'd3;

  localparam logic [3:0] FWD_REG    = 4'd0;
  localparam logic [3:0] FWD_ALUC_M = 4'd1;
  localparam logic [3:0] FWD_PC4_M  = 4'd2;
  localparam logic [3:0] FWD_ALUC_W = 4'd3;
  localparam logic [3:0] FWD_DMRD_W = 4'd4;
  localparam logic [3:0] FWD_PC4_W  = 4'd5;

  localparam logic [3:0] DMF_V2_M   = 4'd0;
  localparam logic [3:0] DMF_ALUC_W = 4'd1;
  localparam logic [3:0] DMF_PC4_W  = 4'd2;
  localparam logic [3:0] DMF_DMRD_W = 4'd3;

  function automatic logic is_alu_funct(input logic [5:0] fn);
    case (fn)
      FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
      FN_XOR, FN_NOR, FN_SLT, FN_SLTU: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  function automatic logic is_md_start(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_SPECIAL) &&
           (fn == FN_MULT || fn == FN_MULTU || fn == FN_DIV || fn == FN_DIVU);
  endfunction

  function automatic logic is_md(input logic [5:0] op, input logic [5:0] fn);
    return is_md_start(op, fn) || ((op == OP_SPECIAL) &&
           (fn == FN_MFHI || fn == FN_MFLO || fn == FN_MTHI || fn == FN_MTLO));
  endfunction

  // The all-zero nop (sll $0,$0,0) falls through to CLS_NONE.
  function automatic prod_cls_t prod_class(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_SPECIAL: begin
        if (is_alu_funct(fn) || fn == FN_MFHI || fn == FN_MFLO) return CLS_ALU;
        else if (fn == FN_JALR)                                 return CLS_LINK;
        else                                                    return CLS_NONE;
      end
      OP_ORI, OP_LUI, OP_ADDIU: return CLS_ALU;
      OP_LW:                    return CLS_LOAD;
      OP_JAL:                   return CLS_LINK;
      default:                  return CLS_NONE;
    endcase
  endfunction

  function automatic tval_t tuse_rs(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_SPECIAL: begin
        if (fn == FN_JR || fn == FN_JALR)                         return T_0;
        else if (is_alu_funct(fn) || is_md_start(fn == fn ? op : op, fn) ||
                 fn == FN_MTHI || fn == FN_MTLO)                  return T_1;
        else                                                      return T_INF;
      end
      OP_BEQ, OP_BNE:                  return T_0;
      OP_ADDIU, OP_ORI, OP_LW, OP_SW:  return T_1;
      default:                         return T_INF;
    endcase
  endfunction

  function automatic tval_t tuse_rt(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_SPECIAL: begin
        if (is_alu_funct(fn) || is_md_start(op, fn)) return T_1;
        else                                         return T_INF;
      end
      OP_BEQ, OP_BNE: return T_0;
      OP_SW:          return T_2;
      default:        return T_INF;
    endcase
  endfunction

  // Cycles until the result exists, seen from the E and M stages (W is always 0).
  function automatic tval_t tnew_e(input prod_cls_t cls);
    case (cls)
      CLS_ALU, CLS_LINK: return T_1;
      CLS_LOAD:          return T_2;
      default:           return T_0;
    endcase
  endfunction

  function automatic tval_t tnew_m(input prod_cls_t cls);
    return (cls == CLS_LOAD) ? T_1 : T_0;
  endfunction

  // M beats W beats the register file; a load sitting in M is never a source.
  function automatic logic [3:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] a3_m, input prod_cls_t cls_m,
                                         input logic [4:0] a3_w, input prod_cls_t cls_w);
    logic [3:0] sel;
    sel = FWD_REG;
    if (src != 5'd0) begin
      if (src == a3_m && cls_m == CLS_ALU)       sel = FWD_ALUC_M;
      else if (src == a3_m && cls_m == CLS_LINK) sel = FWD_PC4_M;
      else if (src == a3_w) begin
        case (cls_w)
          CLS_ALU:  sel = FWD_ALUC_W;
          CLS_LOAD: sel = FWD_DMRD_W;
          CLS_LINK: sel = FWD_PC4_W;
          default:  sel = FWD_REG;
        endcase
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_counter.sv
// rtl/hazard_ctrl_md_busy_counter.sv - busy-cycle counter sequencing the mult/div unit
// Purpose : loads MULT_CYCLES/DIV_CYCLES on start, then counts down to 0 and holds.
// Ports   : clk, reset (async active-low), start, is_div in; md_cnt, md_busy out.
module md_busy_counter #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  output logic [CNT_W-1:0] md_cnt,
  output logic             md_busy
);

  localparam logic [CNT_W-1:0] LOAD_MULT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] LOAD_DIV  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  // A start while still busy simply reloads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt <= '0;
    end else if (start) begin
      md_cnt <= is_div ? LOAD_DIV : LOAD_MULT;
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - ONE;
    end
  end

  assign md_busy = (md_cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall and forwarding controller for the 5-stage MIPS pipeline
// Purpose : decodes each stage, raises stalls on unresolved hazards, drives the
//           forwarding selects and sequences the mult/div busy counter.
// Ports   : clk, reset (async active-low); instr_D/E/M/W, A3_E/M/W in;
//           enPC, enD, clrE, mfcmp1dSel, mfcmp2dSel, mfaluaeSel, mfalubeSel,
//           mfdmSel, md_busy, md_cnt out.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_D,
  input  logic [31:0]      instr_E,
  input  logic [31:0]      instr_M,
  input  logic [31:0]      instr_W,
  input  logic [4:0]       A3_E,
  input  logic [4:0]       A3_M,
  input  logic [4:0]       A3_W,
  output logic             enPC,
  output logic             enD,
  output logic             clrE,
  output logic [3:0]       mfcmp1dSel,
  output logic [3:0]       mfcmp2dSel,
  output logic [3:0]       mfaluaeSel,
  output logic [3:0]       mfalubeSel,
  output logic [3:0]       mfdmSel,
  output logic             md_busy,
  output logic [CNT_W-1:0] md_cnt
);

  logic [5:0] op_D, fn_D, op_E, fn_E, op_M, fn_M, op_W, fn_W;
  logic [4:0] rs_D, rt_D, rs_E, rt_E, rt_M;
  prod_cls_t  cls_E, cls_M, cls_W;
  tval_t      tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
  logic       stall_rs, stall_rt, stall_md, stall, md_start, md_div;
  logic       unused_bits;

  assign op_D = instr_D[31:26];  assign fn_D = instr_D[5:0];
  assign op_E = instr_E[31:26];  assign fn_E = instr_E[5:0];
  assign op_M = instr_M[31:26];  assign fn_M = instr_M[5:0];
  assign op_W = instr_W[31:26];  assign fn_W = instr_W[5:0];
  assign rs_D = instr_D[25:21];  assign rt_D = instr_D[20:16];
  assign rs_E = instr_E[25:21];  assign rt_E = instr_E[20:16];
  assign rt_M = instr_M[20:16];

  assign unused_bits = ^{instr_D[15:6], instr_E[15:6], instr_M[25:21],
                         instr_M[15:6], instr_W[25:6]};

  assign cls_E     = prod_class(op_E, fn_E);
  assign cls_M     = prod_class(op_M, fn_M);
  assign cls_W     = prod_class(op_W, fn_W);
  assign tnew_E    = tnew_e(cls_E);
  assign tnew_M    = tnew_m(cls_M);
  assign tuse_rs_D = tuse_rs(op_D, fn_D);
  assign tuse_rt_D = tuse_rt(op_D, fn_D);

  assign md_start = is_md_start(op_E, fn_E);
  assign md_div   = (fn_E == FN_DIV) || (fn_E == FN_DIVU);

  assign stall_rs = (rs_D != 5'd0) &&
                    ((rs_D == A3_E && tnew_E > tuse_rs_D) ||
                     (rs_D == A3_M && tnew_M > tuse_rs_D));
  assign stall_rt = (rt_D != 5'd0) &&
                    ((rt_D == A3_E && tnew_E > tuse_rt_D) ||
                     (rt_D == A3_M && tnew_M > tuse_rt_D));
  assign stall_md = is_md(op_D, fn_D) && (md_busy || md_start);
  assign stall    = stall_rs || stall_rt || stall_md;

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_cnt (
    .clk     (clk),
    .reset   (reset),
    .start   (md_start),
    .is_div  (md_div),
    .md_cnt  (md_cnt),
    .md_busy (md_busy)
  );

  // Outputs are combinational but are forced to their idle values while reset is held.
  always_comb begin
    enPC       = 1'b1;
    enD        = 1'b1;
    clrE       = 1'b0;
    mfcmp1dSel = FWD_REG;
    mfcmp2dSel = FWD_REG;
    mfaluaeSel = FWD_REG;
    mfalubeSel = FWD_REG;
    mfdmSel    = DMF_V2_M;
    if (reset) begin
      enPC       = !stall;
      enD        = !stall;
      clrE       = stall;
      mfcmp1dSel = fwd_sel(rs_D, A3_M, cls_M, A3_W, cls_W);
      mfcmp2dSel = fwd_sel(rt_D, A3_M, cls_M, A3_W, cls_W);
      mfaluaeSel = fwd_sel(rs_E, A3_M, cls_M, A3_W, cls_W);
      mfalubeSel = fwd_sel(rt_E, A3_M, cls_M, A3_W, cls_W);
      if (op_M == OP_SW && rt_M != 5'd0 && rt_M == A3_W) begin
        case (cls_W)
          CLS_ALU:  mfdmSel = DMF_ALUC_W;
          CLS_LINK: mfdmSel = DMF_PC4_W;
          CLS_LOAD: mfdmSel = DMF_DMRD_W;
          default:  mfdmSel = DMF_V2_M;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard testbench for hazard_ctrl
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_D, instr_E, instr_M, instr_W;
  logic [4:0]  A3_E, A3_M, A3_W;
  logic        enPC, enD, clrE, md_busy;
  logic [3:0]  mfcmp1dSel, mfcmp2dSel, mfaluaeSel, mfalubeSel, mfdmSel, md_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .instr_D(instr_D), .instr_E(instr_E), .instr_M(instr_M), .instr_W(instr_W),
    .A3_E(A3_E), .A3_M(A3_M), .A3_W(A3_W),
    .enPC(enPC), .enD(enD), .clrE(clrE),
    .mfcmp1dSel(mfcmp1dSel), .mfcmp2dSel(mfcmp2dSel),
    .mfaluaeSel(mfaluaeSel), .mfalubeSel(mfalubeSel), .mfdmSel(mfdmSel),
    .md_busy(md_busy), .md_cnt(md_cnt)
  );

  typedef struct packed {
    logic       en_pc, en_d, clr_e;
    logic [3:0] cmp1, cmp2, ae, be, dm, cnt;
    logic       busy;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;

  localparam logic [31:0] NOP = 32'h0;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt);
    return {op, rs, rt, 16'h0000};
  endfunction

  function automatic exp_t mk(input logic stall, input logic [3:0] c1, input logic [3:0] c2,
                              input logic [3:0] ae, input logic [3:0] be,
                              input logic [3:0] dm, input logic [3:0] cnt);
    return {!stall, !stall, stall, c1, c2, ae, be, dm, cnt, cnt != 4'd0};
  endfunction

  task automatic step(input string n, input logic [31:0] d, input logic [31:0] e,
                      input logic [31:0] m, input logic [31:0] w,
                      input logic [4:0] a3e, input logic [4:0] a3m, input logic [4:0] a3w,
                      input logic rst_n, input exp_t x);
    @(posedge clk);
    #1;
    instr_D = d; instr_E = e; instr_M = m; instr_W = w;
    A3_E = a3e; A3_M = a3m; A3_W = a3w; reset = rst_n;
    exp_q.push_back(x);
    name_q.push_back(n);
  endtask

  // Monitor: compares every queued expectation against the outputs at the falling edge.
  always @(negedge clk) begin
    exp_t  e, a;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {enPC, enD, clrE, mfcmp1dSel, mfcmp2dSel, mfaluaeSel, mfalubeSel,
           mfdmSel, md_cnt, md_busy};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s got=%h want=%h", n, a, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [31:0] addu1, beq1, addu5, lw4, addu9, jal, jr31, lw6, sw6, divi, mflo, mult;

  initial begin
    addu1 = rtype(5'd2, 5'd3, 5'd1, 6'h21);
    beq1  = itype(6'h04, 5'd1, 5'd0);
    lw4   = itype(6'h23, 5'd9, 5'd4);
    addu5 = rtype(5'd4, 5'd4, 5'd5, 6'h21);
    addu9 = rtype(5'd1, 5'd1, 5'd9, 6'h21);
    jal   = {6'h03, 26'h0};
    jr31  = rtype(5'd31, 5'd0, 5'd0, 6'h08);
    lw6   = itype(6'h23, 5'd8, 5'd6);
    sw6   = itype(6'h2b, 5'd7, 5'd6);
    divi  = rtype(5'd2, 5'd3, 5'd0, 6'h1a);
    mult  = rtype(5'd2, 5'd3, 5'd0, 6'h18);
    mflo  = rtype(5'd0, 5'd0, 5'd2, 6'h12);

    reset = 1'b0;
    instr_D = NOP; instr_E = NOP; instr_M = NOP; instr_W = NOP;
    A3_E = 5'd0; A3_M = 5'd0; A3_W = 5'd0;

    step("reset_idle",   beq1, addu1, NOP, NOP, 5'd1, 5'd0, 5'd0, 1'b0, mk(0,0,0,0,0,0,0));
    step("alu_e_beq",    beq1, addu1, NOP, NOP, 5'd1, 5'd0, 5'd0, 1'b1, mk(1,0,0,0,0,0,0));
    step("alu_m_beq",    beq1, NOP, addu1, NOP, 5'd0, 5'd1, 5'd0, 1'b1, mk(0,1,0,0,0,0,0));
    step("no_dep",       NOP, NOP, NOP, addu1, 5'd0, 5'd0, 5'd1, 1'b1, mk(0,0,0,0,0,0,0));
    step("reg0_no_stall", itype(6'h04, 5'd0, 5'd0), rtype(5'd2, 5'd3, 5'd0, 6'h21), NOP, NOP,
         5'd0, 5'd0, 5'd0, 1'b1, mk(0,0,0,0,0,0,0));
    step("m_over_w",     NOP, addu9, addu1, addu1, 5'd9, 5'd1, 5'd1, 1'b1, mk(0,0,0,1,1,0,0));
    step("alu_w_to_e",   NOP, addu9, NOP, addu1, 5'd9, 5'd0, 5'd1, 1'b1, mk(0,0,0,3,3,0,0));
    step("lw_e_stall",   addu5, lw4, NOP, NOP, 5'd4, 5'd0, 5'd0, 1'b1, mk(1,0,0,0,0,0,0));
    step("lw_m_nofwd",   addu5, NOP, lw4, NOP, 5'd0, 5'd4, 5'd0, 1'b1, mk(0,0,0,0,0,0,0));
    step("lw_w_to_e",    NOP, addu5, NOP, lw4, 5'd5, 5'd0, 5'd4, 1'b1, mk(0,0,0,4,4,0,0));
    step("jal_e_jr",     jr31, jal, NOP, NOP, 5'd31, 5'd0, 5'd0, 1'b1, mk(1,0,0,0,0,0,0));
    step("jal_m_jr",     jr31, NOP, jal, NOP, 5'd0, 5'd31, 5'd0, 1'b1, mk(0,2,0,0,0,0,0));
    step("jal_w_jr",     jr31, NOP, NOP, jal, 5'd0, 5'd0, 5'd31, 1'b1, mk(0,5,0,0,0,0,0));
    step("sw_lw_w",      NOP, NOP, sw6, lw6, 5'd0, 5'd0, 5'd6, 1'b1, mk(0,0,0,0,0,3,0));
    step("sw_a3w_zero",  NOP, NOP, sw6, lw6, 5'd0, 5'd0, 5'd0, 1'b1, mk(0,0,0,0,0,0,0));

    step("div_start",    mflo, divi, NOP, NOP, 5'd0, 5'd0, 5'd0, 1'b1, mk(1,0,0,0,0,0,0));
    for (int i = 0; i < 10; i++)
      step($sformatf("div_busy_%0d", 10 - i), mflo, NOP, NOP, NOP, 5'd0, 5'd0, 5'd0, 1'b1,
           mk(1,0,0,0,0,0,4'(10 - i)));
    step("div_release",  mflo, NOP, NOP, NOP, 5'd0, 5'd0, 5'd0, 1'b1, mk(0,0,0,0,0,0,0));

    step("mult_start",   NOP, mult, NOP, NOP, 5'd0, 5'd0, 5'd0, 1'b1, mk(0,0,0,0,0,0,0));
    step("mult_cnt5",    NOP, NOP, NOP, NOP, 5'd0, 5'd0, 5'd0, 1'b1, mk(0,0,0,0,0,0,5));
    step("mult_cnt4",    NOP, NOP, NOP, NOP, 5'd0, 5'd0, 5'd0, 1'b1, mk(0,0,0,0,0,0,4));

    // md_cnt is 3 after this edge; reset is pulled mid-cycle with no further clock edge.
    @(posedge clk);
    #1;
    instr_D = mflo; instr_E = rtype(5'd2, 5'd3, 5'd8, 6'h21);
    instr_M = rtype(5'd4, 5'd5, 5'd2, 6'h21); instr_W = NOP;
    A3_E = 5'd8; A3_M = 5'd2; A3_W = 5'd0;
    #1;
    reset = 1'b0;
    exp_q.push_back(mk(0,0,0,0,0,0,0));
    name_q.push_back("async_reset_mid");

    step("post_reset_hold", NOP, NOP, NOP, NOP, 5'd0, 5'd0, 5'd0, 1'b1, mk(0,0,0,0,0,0,0));
    step("post_reset_mflo", mflo, NOP, NOP, NOP, 5'd0, 5'd0, 5'd0, 1'b1, mk(0,0,0,0,0,0,0));

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
